// File: rtl/mux_4x1_arbiter_pkg.sv
// mux_4x1_arbiter_pkg
// Shared constants for the round-robin mux arbiter: FSM state encoding,
// requester count, select width, and the round-robin pick helper.
package mux_4x1_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // First set bit of req in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    // Scanning from the far end lets the nearest hit overwrite the others.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] idx;
        pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_4x1_arbiter_mux.sv
// mux_4x1
// Shared 1-bit 4:1 channel multiplexer.
// Ports: a..d data inputs (index 0..3), sel select, y selected bit.
module mux_4x1
    import mux_4x1_arbiter_pkg::*;
(
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    always_comb begin
        y = a;
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/mux_4x1_arbiter.sv
// mux_4x1_arbiter
// Round-robin arbiter owning the select of a shared mux_4x1 channel.
// The owner keeps the channel until it drops its request; every handover
// passes through one idle cycle.
// Optional: define MUX_ARB_TIMEOUT_EN to build a hold counter that revokes
// a grant after MAX_HOLD cycles (MAX_HOLD legal range 1..15).
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   req    request per requester (bit i = requester i)
//   data   data bit per requester, feeds mux input i
//   grant  registered one-hot grant, zero when idle
//   sel    registered mux select, index of current or last owner
//   busy   registered, high while a grant is active
//   out    data[sel] gated by busy
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | no owner; arbitrate on any request
// ST_GRANT | one owner; hold until release (or timeout)
module mux_4x1_arbiter
    import mux_4x1_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             out
);

    arb_state_t       state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [SEL_W-1:0] pick;
    logic             release_now;
    logic             mux_y;

    assign pick = rr_pick(req, ptr);

`ifdef MUX_ARB_TIMEOUT_EN
    logic [3:0] hold_cnt, hold_cnt_nxt;
    logic       hold_expired;

    assign hold_expired = (hold_cnt == 4'(MAX_HOLD - 1));
    assign release_now  = !req[sel] || hold_expired;

    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (state == ST_IDLE)
            hold_cnt_nxt = '0;
        else if (!release_now)
            hold_cnt_nxt = hold_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) hold_cnt <= '0;
        else       hold_cnt <= hold_cnt_nxt;
    end
`else
    logic [3:0] unused_max_hold;
    assign unused_max_hold = 4'(MAX_HOLD);
    // While granted, sel always names the owner.
    assign release_now = !req[sel];
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        grant_nxt = grant;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt = ST_GRANT;
                    sel_nxt   = pick;
                    grant_nxt = N_REQ'(1) << pick;
                    ptr_nxt   = pick + SEL_W'(1);
                end
            end
            default: begin
                if (release_now) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            sel   <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            grant <= grant_nxt;
            busy  <= (state_nxt == ST_GRANT);
        end
    end

    mux_4x1 u_mux (
        .a   (data[0]),
        .b   (data[1]),
        .c   (data[2]),
        .d   (data[3]),
        .sel (sel),
        .y   (mux_y)
    );

    assign out = busy & mux_y;

endmodule

// File: tb/tb_mux_4x1_arbiter.sv
// tb_mux_4x1_arbiter
// Directed bench for mux_4x1_arbiter. Build with MUX_ARB_TIMEOUT_EN defined
// to exercise the hold-timeout path (MAX_HOLD = 3).
module tb_mux_4x1_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       out;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_4x1_arbiter #(.MAX_HOLD(3)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .data  (data),
        .grant (grant),
        .sel   (sel),
        .busy  (busy),
        .out   (out)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
    endtask

    logic [1:0] rr_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        reset = 1'b1;
        req   = '0;
        data  = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_grant", 8'(grant), 8'h0);
        chk("rst_sel",   8'(sel),   8'h0);
        chk("rst_busy",  8'(busy),  8'h0);
        chk("rst_out",   8'(out),   8'h0);

        // Single request to 2 (ptr -> 3)
        req = 4'b0100; data = 4'b0100;
        tick();
        chk("single_grant", 8'(grant), 8'h4);
        chk("single_sel",   8'(sel),   8'h2);
        chk("single_busy",  8'(busy),  8'h1);
        chk("single_out",   8'(out),   8'h1);
        req = 4'b0000;
        tick();
        chk("single_rel_grant", 8'(grant), 8'h0);
        chk("single_rel_out",   8'(out),   8'h0);
        chk("single_rel_sel",   8'(sel),   8'h2);
        tick();
        chk("idle_stays", 8'(grant), 8'h0);

        // Wrap: ptr=3, req 0011 -> 0 wins, then 1
        req = 4'b0011;
        tick();
        chk("wrap_grant0", 8'(grant), 8'h1);
        req = 4'b0000;
        tick();
        chk("wrap_idle", 8'(busy), 8'h0);
        req = 4'b0011;
        tick();
        chk("skip_grant1", 8'(grant), 8'h2);

        // Data routing with owner 1
        data = 4'b1101;
        #1;
        chk("route_own1", 8'(out), 8'h0);
        data = 4'b0000;
        #1;
        chk("route_own1_tog", 8'(out), 8'h0);
        data = 4'b0010;
        #1;
        chk("route_own1_hi", 8'(out), 8'h1);
        req = 4'b1010;   // new requester 3 ignored while 1 owns
        tick();
        chk("ignore_nonowner", 8'(grant), 8'h2);
        req = 4'b1000;
        tick();
        chk("rel_to_idle", 8'(grant), 8'h0);
        data = 4'b1101;
        tick();
        chk("own3_grant", 8'(grant), 8'h8);
        chk("route_own3",  8'(out), 8'h1);
        data = 4'b1010;
        #1;
        chk("route_own3_tog", 8'(out), 8'h1);
        req = 4'b0000;
        tick();

        // Reset mid-grant: ptr is 0 after the grant to 3
        req = 4'b0100;
        tick();
        chk("mid_grant2", 8'(grant), 8'h4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_grant", 8'(grant), 8'h0);
        chk("midrst_sel",   8'(sel),   8'h0);
        chk("midrst_busy",  8'(busy),  8'h0);
        chk("midrst_out",   8'(out),   8'h0);
        req = 4'b1111;
        tick();
        chk("midrst_ptr0", 8'(grant), 8'h1);

        // Round robin 0,1,2,3,0 with one idle cycle between grants
        do_reset();
        foreach (rr_order[k]) begin
            req = 4'b1111;
            tick();
            chk($sformatf("rr%0d_grant", k), 8'(grant), 8'(4'b0001 << rr_order[k]));
            chk($sformatf("rr%0d_sel", k),   8'(sel),   8'(rr_order[k]));
            tick();
            chk($sformatf("rr%0d_hold", k),  8'(grant), 8'(4'b0001 << rr_order[k]));
            req = 4'b1111 & ~(4'b0001 << rr_order[k]);
            tick();
            chk($sformatf("rr%0d_gap", k),   8'(busy), 8'h0);
        end

        // Long hold / timeout
        do_reset();
        req = 4'b0011;
`ifdef MUX_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("to_a%0d", i), 8'(grant), 8'h1);
        end
        tick();
        chk("to_gap_a", 8'(grant), 8'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("to_b%0d", i), 8'(grant), 8'h2);
        end
        tick();
        chk("to_gap_b", 8'(grant), 8'h0);
`else
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("hold%0d", i), 8'(grant), 8'h1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
